// File: rtl/spi_slave_rx.sv
// SPI mode-0 receive front end: synchronizes sclk/mosi/cs_n into clk and deserializes MSB-first frames.
// Optional stall abort is built only when SPI_RX_TIMEOUT_EN is defined.
//
// state | meaning
// ARM   | after reset or abort; waits for a settled, deasserted cs_n
// IDLE  | waits for cs_n falling edge
// SHIFT | frame in progress, shifting on sclk rising edges
module spi_slave_rx #(
  parameter int DATA_WIDTH     = 24,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sclk,
  input  logic                  spi_mosi,
  input  logic                  spi_cs_n,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_err,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_WIDTH + 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("spi_slave_rx: SYNC_STAGES must be 2..4 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {ARM, IDLE, SHIFT} state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sclk_sync_q, mosi_sync_q, cs_sync_q;
  logic                    sclk_prev_q, cs_prev_q;
  logic [SYNC_STAGES:0]    sync_ok_q;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    rx_err_q, rx_err_d;
  logic                    busy_q;
  logic                    s_sclk, s_mosi, s_cs_n;
  logic                    sclk_rise, cs_fall, cs_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      sync_ok_q   <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      sclk_prev_q <= s_sclk;
      cs_prev_q   <= s_cs_n;
      sync_ok_q   <= {sync_ok_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign s_sclk    = sclk_sync_q[SYNC_STAGES-1];
  assign s_mosi    = mosi_sync_q[SYNC_STAGES-1];
  assign s_cs_n    = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = s_sclk & ~sclk_prev_q;
  assign cs_fall   = ~s_cs_n & cs_prev_q;
  assign cs_rise   = s_cs_n & ~cs_prev_q;

`ifdef SPI_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`endif

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
`ifdef SPI_RX_TIMEOUT_EN
    to_cnt_d   = '0;
`endif
    case (state_q)
      // The synchronizers reset to "cs high"; wait until they hold real samples
      // so a reset released mid-frame is not mistaken for a fresh cs_n fall.
      ARM: if (sync_ok_q[SYNC_STAGES] && s_cs_n) state_d = IDLE;
      IDLE: begin
        if (cs_fall) begin
          shift_d   = '0;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
          if (bit_cnt_q == CNT_FULL) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            rx_err_d = 1'b1;
          end
        end else if (sclk_rise) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], s_mosi};
          if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + 1'b1;
        end
`ifdef SPI_RX_TIMEOUT_EN
        else if (to_cnt_q == TO_MAX) begin
          rx_err_d = 1'b1;
          state_d  = ARM;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = ARM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARM;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      busy_q     <= (state_d == SHIFT);
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;
  assign busy     = busy_q;

endmodule
